dcache_core: RTL and testbench
==============================

DCACHE_CORE -- requirements
Module: dcache_core

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (fixed at 4 for the 128-bit memory bus).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port proc_read  input  1  processor load request.
REQ-006 SHALL have port proc_write  input  1  processor store request.
REQ-007 SHALL have port proc_addr  input  30  word address: tag [29:5], index [4:2], offset [1:0].
REQ-008 SHALL have port proc_wdata  input  32  store data.
REQ-009 SHALL have port proc_rdata  output  32  load data, combinational from the array.
REQ-010 SHALL have port proc_stall  output  1  high while the request cannot complete this cycle.
REQ-011 SHALL have port mem_read  output  1  block read request.
REQ-012 SHALL have port mem_write  output  1  block write request.
REQ-013 SHALL have port mem_addr  output  28  block address {tag, index}.
REQ-014 SHALL have port mem_wdata  output  128  victim block, word 0 in [31:0].
REQ-015 SHALL have port mem_rdata  input  128  fill block, word 0 in [31:0].
REQ-016 SHALL have port mem_ready  input  1  one-cycle pulse; the transfer completes on that cycle.

Function
REQ-017 SHALL store and return data without byte reordering; endianness is handled by the requester.
REQ-018 SHALL implement the FSM states IDLE, WRITEBACK and ALLOCATE.
REQ-019 SHALL, in IDLE, compute hit = valid[index] & (tag match).
REQ-020 SHALL, on a hit or with no request, hold proc_stall low in the same cycle (zero-wait hit).
REQ-021 SHALL, on a read hit, drive proc_rdata with word[offset] combinationally.
REQ-022 SHALL, on a write hit, update word[offset] and set dirty[index] at the clock edge.
REQ-023 SHALL, on a miss, raise proc_stall combinationally and move to WRITEBACK if dirty[index] is set, otherwise to ALLOCATE.
REQ-024 SHALL, in WRITEBACK, drive mem_write=1, mem_addr={stored tag, index}, mem_wdata=line, and move to ALLOCATE on mem_ready.
REQ-025 SHALL, in ALLOCATE, drive mem_read=1, mem_addr={request tag, index}; on mem_ready, write the line with mem_rdata, set the tag, set valid=1, clear dirty, and return to IDLE.
REQ-026 SHALL complete the access as a hit on the first IDLE cycle after a refill; stall spans miss detection through that cycle (exclusive).
REQ-027 SHALL hold proc_stall high in WRITEBACK and ALLOCATE, ignoring requester changes; the requester keeps its request stable while stalled.
REQ-028 SHALL give proc_write priority when proc_read and proc_write are both high.
REQ-029 SHALL keep mem_read and mem_write mutually exclusive and deassert both in IDLE.
REQ-030 SHALL drive proc_rdata to 0 when no read hit is present.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, go to IDLE and clear every valid and dirty bit.
REQ-032 SHALL hold outputs after reset at proc_stall=0 (no request), mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-033 SHALL, on reset during WRITEBACK or ALLOCATE, abort the transfer, discard dirty data, and ignore any later mem_ready.
REQ-034 SHALL leave the data and tag arrays non-reset.

Configuration
REQ-035 SHALL gate the 32-bit performance outputs hit_cnt and miss_cnt with macro DCACHE_PERF_CNT_EN.
REQ-036 SHALL, with DCACHE_PERF_CNT_EN defined, increment miss_cnt on each IDLE-to-WRITEBACK/ALLOCATE transition.
REQ-037 SHALL, with DCACHE_PERF_CNT_EN defined, increment hit_cnt on each first-attempt hit, excluding the post-refill completion cycle.
REQ-038 SHALL, with DCACHE_PERF_CNT_EN defined, let both counters wrap modulo 2^32 and reset to 0.
REQ-039 SHALL, without DCACHE_PERF_CNT_EN, omit both ports and both counters; all other behaviour is identical.

Verification
REQ-040 SHALL cover a cold read miss: reset, read addr 0x0000_0005, memory returns a block with word1=0x1122_3344 after 3 cycles -> mem_read=1 with mem_addr=0x000_0001 until mem_ready, stall drops the cycle after, proc_rdata=0x1122_3344.
REQ-041 SHALL cover a write hit: write 0xDEAD_BEEF to the same line, then read it back -> no stall on either access, readback 0xDEAD_BEEF, no memory traffic.
REQ-042 SHALL cover a dirty eviction: read addr 0x0000_0025 (same index 1, new tag) after REQ-041 -> mem_write with mem_addr=0x000_0001 and mem_wdata[63:32]=0xDEAD_BEEF, then mem_read with mem_addr=0x000_0009.
REQ-043 SHALL cover a clean eviction: miss on a clean valid line -> no mem_write, direct ALLOCATE.
REQ-044 SHALL cover reset mid-ALLOCATE: assert rst_n=0 while mem_read=1 -> next cycle IDLE with mem_read=0, and a subsequent read of the same address misses again.
REQ-045 SHALL cover the counters with DCACHE_PERF_CNT_EN defined: run REQ-040 through REQ-042 -> hit_cnt=2, miss_cnt=2.

Source files
------------

// File: rtl/dcache_core_if.sv
// dcache_core_if: processor-side and memory-side signal bundle for dcache_core.
// slave  : the cache (takes processor requests, issues block transfers).
// master : the environment (processor + memory model).
interface dcache_core_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_core.sv
// dcache_core: direct-mapped, write-back, write-allocate data cache.
// Zero-wait hits; misses go IDLE -> [WRITEBACK] -> ALLOCATE -> IDLE, and the
// access then completes as a hit on the first IDLE cycle after the refill.
// Optional feature macro: DCACHE_PERF_CNT_EN adds 32-bit hit_cnt / miss_cnt outputs.
module dcache_core #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_core_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t r_state, w_next;

    // Line storage; data and tags carry no reset, only valid/dirty do.
    logic [WORDS_PER_LINE-1:0][31:0] r_data [NUM_LINES];
    logic [TAG_W-1:0]                r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]            r_valid;
    logic [NUM_LINES-1:0]            r_dirty;

    logic [TAG_W-1:0]                w_tag;
    logic [IDX_W-1:0]                w_idx;
    logic [1:0]                      w_off;
    logic                            w_req;
    logic                            w_hit;
    logic [WORDS_PER_LINE-1:0][31:0] w_line;
    logic                            w_wr_hit;
    logic                            w_rd_hit;
    logic                            w_miss;
    logic                            w_fill;

    logic         w_stall;
    logic [31:0]  w_rdata;
    logic         w_mem_read;
    logic         w_mem_write;
    logic [27:0]  w_mem_addr;
    logic [127:0] w_mem_wdata;

    assign w_tag  = bus.proc_addr[29 -: TAG_W];
    assign w_idx  = bus.proc_addr[2 +: IDX_W];
    assign w_off  = bus.proc_addr[1:0];
    assign w_req  = bus.proc_read | bus.proc_write;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line = r_data[w_idx];
    assign w_fill = (r_state == ALLOCATE) && bus.mem_ready;

    assign bus.proc_stall = w_stall;
    assign bus.proc_rdata = w_rdata;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;

    // State register; a synchronous reset aborts any block transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and all outputs; stores win over loads when both are raised.
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_rdata     = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_wr_hit    = 1'b0;
        w_rd_hit    = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (bus.proc_write) begin
                            w_wr_hit = 1'b1;
                        end else begin
                            w_rd_hit = 1'b1;
                            w_rdata  = w_line[w_off];
                        end
                    end else begin
                        w_stall = 1'b1;
                        w_miss  = 1'b1;
                        w_next  = r_dirty[w_idx] ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                w_stall     = 1'b1;
                w_mem_write = 1'b1;
                w_mem_addr  = {r_tag[w_idx], w_idx};
                w_mem_wdata = w_line;
                if (bus.mem_ready) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                w_stall    = 1'b1;
                w_mem_read = 1'b1;
                w_mem_addr = {w_tag, w_idx};
                if (bus.mem_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Valid/dirty bookkeeping: stores dirty the line, a refill makes it clean and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end
    end

    // Data and tag arrays: word store on a write hit, whole-line replace on refill.
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_data[w_idx][w_off] <= bus.proc_wdata;
        end
        if (w_fill) begin
            r_data[w_idx] <= bus.mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        r_refill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // Event counters; the hit that completes a refilled miss is not a first-attempt hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refill <= w_fill;
            if ((w_wr_hit || w_rd_hit) && !r_refill) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_core.sv
// tb_dcache_core: directed checks of dcache_core with a hand-driven memory side.
module tb_dcache_core;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    localparam logic [127:0] FILL_A = {32'hA000_0003, 32'hA000_0002, 32'h1122_3344, 32'hA000_0000};
    localparam logic [127:0] FILL_B = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    localparam logic [127:0] FILL_C = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    localparam logic [127:0] FILL_D = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    dcache_core_if bus ();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    dcache_core dut (.clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
    dcache_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n           = 1'b0;
        bus.proc_read   = 1'b0;
        bus.proc_write  = 1'b0;
        bus.proc_addr   = '0;
        bus.proc_wdata  = '0;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;
        @(negedge clk);
        step();

        // reset state
        chk("rst_stall", bus.proc_stall, 1'b0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 28'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
`ifdef DCACHE_PERF_CNT_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst_n = 1'b1;

        // cold read miss at word address 0x5
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h5;
        #1;
        chk("cold_stall", bus.proc_stall, 1'b1);
        chk("cold_rdata0", bus.proc_rdata, 32'h0);
        chk("cold_idle_memrd", bus.mem_read, 1'b0);
        step();
        for (int c = 0; c < 3; c++) begin
            chk("cold_alloc_rd", bus.mem_read, 1'b1);
            chk("cold_alloc_wr", bus.mem_write, 1'b0);
            chk("cold_alloc_addr", bus.mem_addr, 28'h1);
            chk("cold_alloc_stall", bus.proc_stall, 1'b1);
            if (c == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = FILL_A;
            end
            step();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("cold_done_stall", bus.proc_stall, 1'b0);
        chk("cold_done_rdata", bus.proc_rdata, 32'h1122_3344);
        chk("cold_done_memrd", bus.mem_read, 1'b0);
        step();

        // write hit, then read back
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b1;
        bus.proc_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_stall", bus.proc_stall, 1'b0);
        chk("wr_memrd", bus.mem_read, 1'b0);
        chk("wr_memwr", bus.mem_write, 1'b0);
        step();
        bus.proc_write = 1'b0;
        bus.proc_read  = 1'b1;
        #1;
        chk("rb_stall", bus.proc_stall, 1'b0);
        chk("rb_rdata", bus.proc_rdata, 32'hDEAD_BEEF);
        chk("rb_memrd", bus.mem_read, 1'b0);
        step();

        // dirty eviction: 0x25 maps to index 1 with tag 1
        bus.proc_addr = 30'h25;
        #1;
        chk("ev_stall", bus.proc_stall, 1'b1);
        step();
        chk("ev_wb_wr", bus.mem_write, 1'b1);
        chk("ev_wb_rd", bus.mem_read, 1'b0);
        chk("ev_wb_addr", bus.mem_addr, 28'h1);
        chk("ev_wb_word1", bus.mem_wdata[63:32], 32'hDEAD_BEEF);
        chk("ev_wb_line", bus.mem_wdata, {32'hA000_0003, 32'hA000_0002, 32'hDEAD_BEEF, 32'hA000_0000});
        chk("ev_wb_stall", bus.proc_stall, 1'b1);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("ev_alloc_rd", bus.mem_read, 1'b1);
        chk("ev_alloc_wr", bus.mem_write, 1'b0);
        chk("ev_alloc_addr", bus.mem_addr, 28'h9);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = FILL_B;
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("ev_done_stall", bus.proc_stall, 1'b0);
        chk("ev_done_rdata", bus.proc_rdata, 32'hB000_0001);
        step();
`ifdef DCACHE_PERF_CNT_EN
        chk("perf_hit_cnt", hit_cnt, 32'd2);
        chk("perf_miss_cnt", miss_cnt, 32'd2);
`endif

        // clean eviction: back to 0x5 over the clean tag-1 line
        bus.proc_addr = 30'h5;
        #1;
        chk("ce_stall", bus.proc_stall, 1'b1);
        step();
        chk("ce_wr", bus.mem_write, 1'b0);
        chk("ce_rd", bus.mem_read, 1'b1);
        chk("ce_addr", bus.mem_addr, 28'h1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = FILL_C;
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("ce_done_stall", bus.proc_stall, 1'b0);
        chk("ce_done_rdata", bus.proc_rdata, 32'hC000_0001);
        step();

        // reset in the middle of ALLOCATE, with a coincident mem_ready
        bus.proc_addr = 30'h45;
        #1;
        step();
        chk("rm_rd", bus.mem_read, 1'b1);
        chk("rm_addr", bus.mem_addr, 28'h11);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = FILL_D;
        step();
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.proc_read = 1'b0;
        #1;
        chk("rm_idle_rd", bus.mem_read, 1'b0);
        chk("rm_idle_stall", bus.proc_stall, 1'b0);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("stray_rd", bus.mem_read, 1'b0);
        chk("stray_wr", bus.mem_write, 1'b0);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h5;
        #1;
        chk("rm_old_line_miss", bus.proc_stall, 1'b1);
        bus.proc_addr = 30'h45;
        #1;
        chk("rm_remiss", bus.proc_stall, 1'b1);
        step();
        chk("rm_realloc_rd", bus.mem_read, 1'b1);
        chk("rm_realloc_addr", bus.mem_addr, 28'h11);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = FILL_D;
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("rm_fill_rdata", bus.proc_rdata, 32'hD000_0001);
        chk("rm_fill_stall", bus.proc_stall, 1'b0);
        step();

        // other offsets of the refilled line
        bus.proc_addr = 30'h44;
        #1;
        chk("off0_rdata", bus.proc_rdata, 32'hD000_0000);
        bus.proc_addr = 30'h47;
        #1;
        chk("off3_rdata", bus.proc_rdata, 32'hD000_0003);

        // simultaneous read and write: the store wins, no load data
        bus.proc_addr  = 30'h45;
        bus.proc_write = 1'b1;
        bus.proc_wdata = 32'hCAFE_F00D;
        #1;
        chk("wp_rdata", bus.proc_rdata, 32'h0);
        chk("wp_stall", bus.proc_stall, 1'b0);
        step();
        bus.proc_write = 1'b0;
        #1;
        chk("wp_readback", bus.proc_rdata, 32'hCAFE_F00D);

        // no request: no stall, no load data
        bus.proc_read = 1'b0;
        bus.proc_addr = 30'h3FF;
        #1;
        chk("idle_stall", bus.proc_stall, 1'b0);
        chk("idle_rdata", bus.proc_rdata, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
